// File: rtl/riscv_defines.sv
// Shared definitions for the instruction port arbiter.
//   owner_t      : ID of the master(s) a memory transaction belongs to.
//                  BOTH exists only when RISCV_INSTR_ARB_LOCKSTEP_EN is defined.
//   arb_state_t  : selection-lock state of the arbiter.
//   owner_onehot : maps an owner ID onto the per-master bit vector.
// Optional feature macro: RISCV_INSTR_ARB_LOCKSTEP_EN (merged lockstep fetch).
package riscv_defines;

   localparam int unsigned NUM_MASTERS = 2;
   localparam int unsigned ADDR_WIDTH  = 32;

`ifdef RISCV_INSTR_ARB_LOCKSTEP_EN
   typedef enum logic [1:0] {
      MASTER0 = 2'd0,
      MASTER1 = 2'd1,
      BOTH    = 2'd2
   } owner_t;
`else
   typedef enum logic {
      MASTER0 = 1'b0,
      MASTER1 = 1'b1
   } owner_t;
`endif

   typedef enum logic {
      ARB_FREE,
      ARB_LOCKED
   } arb_state_t;

   function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t owner);
      logic [NUM_MASTERS-1:0] oh;
      oh = '0;
      case (owner)
         MASTER0: oh = 2'b01;
         MASTER1: oh = 2'b10;
`ifdef RISCV_INSTR_ARB_LOCKSTEP_EN
         BOTH:    oh = 2'b11;
`endif
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/riscv_arb_id_fifo.sv
// Owner-ID FIFO: records which master(s) each granted memory transaction
// belongs to, so in-order responses can be routed back.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push_i      : write push_id_i (accepted when not full, or full with pop)
//   push_id_i   : owner of the transaction being granted
//   pop_i       : remove head (ignored while empty)
//   head_o      : owner ID at the head
//   full_o      : DEPTH entries stored
//   empty_o     : no entries stored
module riscv_arb_id_fifo
   import riscv_defines::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  owner_t push_id_i,
   input  logic   pop_i,
   output owner_t head_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   owner_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_id_i;
      end
   end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Two-master instruction fetch port arbiter onto one memory port.
// Round-robin selection, locked while a request waits for grant; responses
// are routed back in order using an owner-ID FIFO.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   m_req_i/m_addr_i  : per-master request and fetch address
//   m_gnt_o/m_rvalid_o: per-master grant and response valid
//   m_rdata_o/m_err_o : shared response data / PMP error
//   mem_*             : memory-side request/response port
//   lockstep_mode_i   : enables merged fetch of identical addresses
//   busy_o            : transactions outstanding
// Optional feature macro: RISCV_INSTR_ARB_LOCKSTEP_EN -- when defined, equal
// addresses in lockstep mode are fetched once and answered to both masters.
module riscv_instr_port_arbiter
   import riscv_defines::*;
#(
   parameter int unsigned RDATA_WIDTH     = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_MASTERS-1:0]                 m_req_i,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
   output logic [NUM_MASTERS-1:0]                 m_gnt_o,
   output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
   output logic [RDATA_WIDTH-1:0]                 m_rdata_o,
   output logic                                   m_err_o,
   output logic                                   mem_req_o,
   output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
   input  logic                                   mem_gnt_i,
   input  logic                                   mem_rvalid_i,
   input  logic [RDATA_WIDTH-1:0]                 mem_rdata_i,
   input  logic                                   mem_err_i,
   input  logic                                   lockstep_mode_i,
   output logic                                   busy_o
);

   arb_state_t             state_q, state_d;
   owner_t                 lock_id_q, lock_id_d;
   logic                   prio_q, prio_d;
   owner_t                 req_owner;
   owner_t                 head_id;
   logic [NUM_MASTERS-1:0] req_oh;
   logic [NUM_MASTERS-1:0] lock_oh;
   logic                   lock_hold;
   logic                   has_req;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   push;

`ifdef RISCV_INSTR_ARB_LOCKSTEP_EN
   logic merge_ok;
   assign merge_ok = lockstep_mode_i & m_req_i[0] & m_req_i[1]
                     & (m_addr_i[0] == m_addr_i[1]);
`else
   logic unused_lockstep;
   assign unused_lockstep = lockstep_mode_i;
`endif

   // The lock only holds while every master it names still requests, so a
   // withdrawn request releases it in the same cycle.
   assign lock_oh   = owner_onehot(lock_id_q);
   assign lock_hold = (state_q == ARB_LOCKED) && ((m_req_i & lock_oh) == lock_oh);

   always_comb begin
      req_owner = MASTER0;
      if (lock_hold) begin
         req_owner = lock_id_q;
`ifdef RISCV_INSTR_ARB_LOCKSTEP_EN
      end else if (merge_ok) begin
         req_owner = BOTH;
`endif
      end else if (m_req_i == 2'b11) begin
         req_owner = prio_q ? MASTER1 : MASTER0;
      end else if (m_req_i[1]) begin
         req_owner = MASTER1;
      end
   end

   assign req_oh  = owner_onehot(req_owner);
   assign has_req = ((m_req_i & req_oh) == req_oh);

   assign pop       = mem_rvalid_i & ~fifo_empty & ~rst;
   assign mem_req_o = has_req & (~fifo_full | pop) & ~rst;
   assign push      = mem_req_o & mem_gnt_i;

   // A merged request uses master 0's address, identical by construction.
   assign mem_addr_o = rst ? '0 : ((req_owner == MASTER1) ? m_addr_i[1] : m_addr_i[0]);
   assign m_gnt_o    = push ? req_oh : '0;
   assign m_rvalid_o = pop ? owner_onehot(head_id) : '0;
   assign m_rdata_o  = rst ? '0 : mem_rdata_i;
   assign m_err_o    = mem_err_i & ~rst;
   assign busy_o     = ~fifo_empty & ~rst;

   always_comb begin
      state_d   = ARB_FREE;
      lock_id_d = lock_id_q;
      prio_d    = prio_q;
      if (mem_req_o && !mem_gnt_i) begin
         state_d   = ARB_LOCKED;
         lock_id_d = req_owner;
      end
      if (push) begin
         case (req_owner)
            MASTER0: prio_d = 1'b1;
            MASTER1: prio_d = 1'b0;
            default: prio_d = prio_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_FREE;
         lock_id_q <= MASTER0;
         prio_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         prio_q    <= prio_d;
      end
   end

   riscv_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push),
      .push_id_i (req_owner),
      .pop_i     (pop),
      .head_o    (head_id),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
module tb_riscv_instr_port_arbiter;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       m_req;
   logic [1:0][31:0] m_addr;
   logic [1:0]       m_gnt;
   logic [1:0]       m_rvalid;
   logic [31:0]      m_rdata;
   logic             m_err;
   logic             mem_req;
   logic [31:0]      mem_addr;
   logic             mem_gnt;
   logic             mem_rvalid;
   logic [31:0]      mem_rdata;
   logic             mem_err;
   logic             lockstep;
   logic             busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   riscv_instr_port_arbiter #(
      .RDATA_WIDTH     (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .m_req_i         (m_req),
      .m_addr_i        (m_addr),
      .m_gnt_o         (m_gnt),
      .m_rvalid_o      (m_rvalid),
      .m_rdata_o       (m_rdata),
      .m_err_o         (m_err),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_gnt_i       (mem_gnt),
      .mem_rvalid_i    (mem_rvalid),
      .mem_rdata_i     (mem_rdata),
      .mem_err_i       (mem_err),
      .lockstep_mode_i (lockstep),
      .busy_o          (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs shortly after the rising edge, then let the
   // combinational outputs settle before checks.
   task automatic apply(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic err);
      m_req      = req;
      m_addr[0]  = a0;
      m_addr[1]  = a1;
      mem_gnt    = gnt;
      mem_rvalid = rv;
      mem_rdata  = rd;
      mem_err    = err;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b1;
      lockstep = 1'b0;
      apply(2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hDEAD, 1'b1);
      step();
      step();
      // outputs held low during reset
      check("rst_mem_req", mem_req, 0);
      check("rst_gnt", m_gnt, 0);
      check("rst_rvalid", m_rvalid, 0);
      check("rst_rdata", m_rdata, 0);
      check("rst_err", m_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // round-robin, grant every cycle, response each cycle
      apply(2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'h0, 1'b0);
      check("rr0_addr", mem_addr, 32'h100);
      check("rr0_gnt", m_gnt, 2'b01);
      check("rr0_rvalid", m_rvalid, 2'b00);
      step();
      check("rr1_addr", mem_addr, 32'h200);
      check("rr1_gnt", m_gnt, 2'b10);
      check("rr1_rvalid", m_rvalid, 2'b01);
      step();
      check("rr2_addr", mem_addr, 32'h100);
      check("rr2_gnt", m_gnt, 2'b01);
      check("rr2_rvalid", m_rvalid, 2'b10);
      step();
      check("rr3_gnt", m_gnt, 2'b10);
      check("rr3_rvalid", m_rvalid, 2'b01);
      step();
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h0, 1'b0);
      check("rr4_rvalid", m_rvalid, 2'b10);
      step();
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rr_idle_busy", busy, 0);

      // grant master 0 once so the pointer favours master 1, then drain
      apply(2'b01, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      check("pre_gnt", m_gnt, 2'b01);
      step();
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h0, 1'b0);
      check("pre_rvalid", m_rvalid, 2'b01);
      step();

      // selection lock: master 0 waits 3 cycles, master 1 joins with priority
      apply(2'b01, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
      check("lock0_req", mem_req, 1);
      check("lock0_addr", mem_addr, 32'h100);
      check("lock0_gnt", m_gnt, 2'b00);
      step();
      apply(2'b11, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
      check("lock1_addr", mem_addr, 32'h100);
      step();
      check("lock2_addr", mem_addr, 32'h100);
      step();
      apply(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      check("lock3_addr", mem_addr, 32'h100);
      check("lock3_gnt", m_gnt, 2'b01);
      step();
      apply(2'b10, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      check("lock4_addr", mem_addr, 32'h200);
      check("lock4_gnt", m_gnt, 2'b10);
      step();

      // FIFO full (M0,M1 outstanding): request must be held off
      apply(2'b01, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      check("full_mem_req", mem_req, 0);
      check("full_gnt", m_gnt, 2'b00);
      check("full_busy", busy, 1);
      step();
      // response and new grant in the same cycle
      apply(2'b01, 32'h100, 32'h200, 1'b1, 1'b1, 32'hA, 1'b0);
      check("pp_rvalid", m_rvalid, 2'b01);
      check("pp_rdata", m_rdata, 32'hA);
      check("pp_err", m_err, 0);
      check("pp_mem_req", mem_req, 1);
      check("pp_gnt", m_gnt, 2'b01);
      step();
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'hB, 1'b1);
      check("resp_m1_rvalid", m_rvalid, 2'b10);
      check("resp_m1_rdata", m_rdata, 32'hB);
      check("resp_m1_err", m_err, 1);
      check("resp_m1_mem_req", mem_req, 0);
      step();
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'hC, 1'b0);
      check("resp_m0_rvalid", m_rvalid, 2'b01);
      check("resp_m0_rdata", m_rdata, 32'hC);
      check("resp_m0_err", m_err, 0);
      step();
      // stray response with nothing outstanding
      check("stray_rvalid", m_rvalid, 2'b00);
      check("stray_busy", busy, 0);
      step();

      // reset with one transaction in flight
      apply(2'b01, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      check("inflight_gnt", m_gnt, 2'b01);
      step();
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
      check("inflight_busy", busy, 1);
      rst = 1'b1;
      apply(2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'h0, 1'b0);
      check("mid_rst_rvalid", m_rvalid, 2'b00);
      check("mid_rst_gnt", m_gnt, 2'b00);
      step();
      rst = 1'b0;
      apply(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h0, 1'b0);
      check("post_rst_rvalid", m_rvalid, 2'b00);
      check("post_rst_busy", busy, 0);
      step();

      lockstep = 1'b1;
`ifdef RISCV_INSTR_ARB_LOCKSTEP_EN
      apply(2'b11, 32'h80, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
      check("ls_mem_req", mem_req, 1);
      check("ls_addr", mem_addr, 32'h80);
      check("ls_wait_gnt", m_gnt, 2'b00);
      step();
      apply(2'b11, 32'h80, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
      check("ls_gnt", m_gnt, 2'b11);
      step();
      apply(2'b00, 32'h80, 32'h80, 1'b0, 1'b1, 32'h55, 1'b0);
      check("ls_busy", busy, 1);
      check("ls_rvalid", m_rvalid, 2'b11);
      check("ls_rdata", m_rdata, 32'h55);
      step();
      apply(2'b11, 32'h80, 32'h84, 1'b1, 1'b0, 32'h0, 1'b0);
      check("ls_diff_gnt", m_gnt, 2'b01);
      check("ls_diff_addr", mem_addr, 32'h80);
      step();
      apply(2'b00, 32'h80, 32'h84, 1'b0, 1'b1, 32'h0, 1'b0);
      check("ls_diff_rvalid", m_rvalid, 2'b01);
      step();
`else
      apply(2'b11, 32'h80, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
      check("nols_gnt0", m_gnt, 2'b01);
      check("nols_addr", mem_addr, 32'h80);
      step();
      check("nols_gnt1", m_gnt, 2'b10);
      step();
      apply(2'b00, 32'h80, 32'h80, 1'b0, 1'b1, 32'h0, 1'b0);
      check("nols_rvalid0", m_rvalid, 2'b01);
      step();
      check("nols_rvalid1", m_rvalid, 2'b10);
      step();
`endif
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("end_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
